// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared definitions for the bus cycle controller: FSM states and parameter defaults.
package bus_cycle_ctrl_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int QCNT_W = 3;

    localparam int                QUEUE_DEPTH_DEF  = 4;
    localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 20'hFFFF0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T1      = 3'd1,
        T2      = 3'd2,
        T3      = 3'd3,
        TW      = 3'd4,
        T4      = 3'd5,
        HOLD_ST = 3'd6
    } state_t;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Bundle of execution-unit, external-bus and prefetch-queue signals around the controller.
interface bus_cycle_ctrl_if;
    import bus_cycle_ctrl_pkg::*;

    logic              REQ;
    logic              REQ_WR;
    logic              REQ_IO;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              ACK;
    logic [DATA_W-1:0] RDATA;
    logic              READY;
    logic              HOLD;
    logic              HLDA;
    logic              ALE;
    logic              RD_N;
    logic              WR_N;
    logic              DEN_N;
    logic              DTR;
    logic              IOM;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] AD_OUT;
    logic              AD_OE;
    logic [DATA_W-1:0] AD_IN;
    logic              QUEUE_ENA;
    logic [DATA_W-1:0] QUEUE_IN;
    logic              QUEUE_POP;
    logic              QUEUE_FLUSH;
    logic [ADDR_W-1:0] NEW_PC;
    logic [QCNT_W-1:0] QCOUNT;

    // Controller side
    modport slave (
        input  REQ, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY, HOLD, AD_IN,
               QUEUE_POP, QUEUE_FLUSH, NEW_PC,
        output ACK, RDATA, HLDA, ALE, RD_N, WR_N, DEN_N, DTR, IOM, A, AD_OUT,
               AD_OE, QUEUE_ENA, QUEUE_IN, QCOUNT
    );

    // Environment side (execution unit, bus, queue)
    modport master (
        output REQ, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY, HOLD, AD_IN,
               QUEUE_POP, QUEUE_FLUSH, NEW_PC,
        input  ACK, RDATA, HLDA, ALE, RD_N, WR_N, DEN_N, DTR, IOM, A, AD_OUT,
               AD_OE, QUEUE_ENA, QUEUE_IN, QCOUNT
    );

endinterface

// File: rtl/bus_cycle_ctrl_prefetch.sv
// Prefetch address counter and queue occupancy count.
module biu_prefetch_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int                QUEUE_DEPTH  = QUEUE_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pf_addr,
    output logic [QCNT_W-1:0] qcount,
    output logic              q_full
);

    localparam logic [QCNT_W-1:0] DEPTH_Q = QCNT_W'(QUEUE_DEPTH);

    logic pop_ok;
    logic push_ok;

    // A pop on an empty queue is dropped; a push is refused when full unless a pop frees a slot
    assign pop_ok  = pop && (qcount != '0);
    assign push_ok = push && ((qcount < DEPTH_Q) || pop_ok);
    assign q_full  = (qcount >= DEPTH_Q);

    // Flush wins over push/pop; the address only advances when a byte actually enters the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcount  <= '0;
            pf_addr <= RESET_VECTOR;
        end else if (flush) begin
            qcount  <= '0;
            pf_addr <= new_pc;
        end else begin
            if (push_ok) begin
                pf_addr <= pf_addr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   qcount <= qcount + 1'b1;
                2'b01:   qcount <= qcount - 1'b1;
                default: qcount <= qcount;
            endcase
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus interface unit: runs T1..T4 bus cycles for execution requests and code prefetch.
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int                QUEUE_DEPTH  = QUEUE_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    bus_cycle_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic              cyc_exec;
    logic              cyc_wr;
    logic              cyc_io;
    logic              discard;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] cap_q;
    logic [ADDR_W-1:0] pf_addr;
    logic [QCNT_W-1:0] qcount;
    logic              q_full;
    logic              busy;
    logic              strobe;
    logic              start_exec;
    logic              start_pf;
    logic              capture;
    logic              push;

    assign busy    = (state == T1) || (state == T2) || (state == T3) ||
                     (state == TW) || (state == T4);
    assign strobe  = (state == T2) || (state == T3) || (state == TW);
    assign capture = ((state == T3) || (state == TW)) && bus.READY;

    // Arbitration in IDLE: hold, then execution request, then prefetch when there is room
    assign start_exec = (state == IDLE) && !bus.HOLD && bus.REQ;
    assign start_pf   = (state == IDLE) && !bus.HOLD && !bus.REQ && !q_full && !bus.QUEUE_FLUSH;

    // A flush in the final cycle also suppresses the push, not only one seen earlier in the cycle
    assign push = (state == T4) && !cyc_exec && !discard && !bus.QUEUE_FLUSH;

    biu_prefetch_ctrl #(
        .QUEUE_DEPTH  (QUEUE_DEPTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_prefetch (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push),
        .pop     (bus.QUEUE_POP),
        .flush   (bus.QUEUE_FLUSH),
        .new_pc  (bus.NEW_PC),
        .pf_addr (pf_addr),
        .qcount  (qcount),
        .q_full  (q_full)
    );

    // Next-state decode; wait states are inserted while READY is low in T3/TW
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.HOLD)                  state_nxt = HOLD_ST;
                else if (start_exec || start_pf) state_nxt = T1;
            end
            T1:      state_nxt = T2;
            T2:      state_nxt = T3;
            T3, TW:  state_nxt = bus.READY ? T4 : TW;
            T4:      state_nxt = IDLE;
            HOLD_ST: if (!bus.HOLD) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any cycle in progress
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latch cycle attributes at T1 entry so A/IOM/DTR/write data stay stable through T4
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_exec <= 1'b0;
            cyc_wr   <= 1'b0;
            cyc_io   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (start_exec) begin
            cyc_exec <= 1'b1;
            cyc_wr   <= bus.REQ_WR;
            cyc_io   <= bus.REQ_IO;
            addr_q   <= bus.REQ_ADDR;
            wdata_q  <= bus.REQ_WDATA;
        end else if (start_pf) begin
            cyc_exec <= 1'b0;
            cyc_wr   <= 1'b0;
            cyc_io   <= 1'b0;
            addr_q   <= pf_addr;
        end
    end

    // Remember a flush that lands on an in-flight prefetch so its byte is dropped at T4
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                        discard <= 1'b0;
        else if (start_exec || start_pf)                   discard <= 1'b0;
        else if (bus.QUEUE_FLUSH && busy && !cyc_exec)     discard <= 1'b1;
    end

    // Sample AD on the READY edge: execution reads go to RDATA, prefetches to the queue byte
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata_q <= '0;
            cap_q   <= '0;
        end else if (capture) begin
            if (cyc_exec && !cyc_wr) rdata_q <= bus.AD_IN;
            if (!cyc_exec)           cap_q   <= bus.AD_IN;
        end
    end

    assign bus.ACK       = (state == T4) && cyc_exec;
    assign bus.RDATA     = rdata_q;
    assign bus.HLDA      = (state == HOLD_ST);
    assign bus.ALE       = (state == T1);
    assign bus.RD_N      = !(strobe && !cyc_wr);
    assign bus.WR_N      = !(strobe && cyc_wr);
    assign bus.DEN_N     = !strobe;
    assign bus.DTR       = busy && cyc_wr;
    assign bus.IOM       = busy && cyc_io;
    assign bus.A         = addr_q;
    assign bus.AD_OUT    = wdata_q;
    assign bus.AD_OE     = cyc_wr && (strobe || (state == T4));
    assign bus.QUEUE_ENA = push;
    assign bus.QUEUE_IN  = cap_q;
    assign bus.QCOUNT    = qcount;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: prefetch table after reset plus hand-written corner sequences.
module tb_bus_cycle_ctrl;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    bus_cycle_ctrl_if bus ();

    bus_cycle_ctrl #(
        .QUEUE_DEPTH  (4),
        .RESET_VECTOR (20'hFFFF0)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  ad_in;
        logic        ale;
        logic        rd_n;
        logic        den_n;
        logic        qena;
        logic [19:0] a;
        logic [7:0]  qin;
        logic [2:0]  qc;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic exec_cycle(input string nm, input logic wr, input logic io,
                              input logic [19:0] addr, input logic [7:0] wd,
                              input logic [7:0] adin, input int waits);
        int          ack_at = 0;
        int          rdlow  = 0;
        int          wrlow  = 0;
        int          oecnt  = 0;
        logic [7:0]  adout_seen = 8'h00;
        logic [19:0] a_t1 = 20'h0;
        logic [19:0] a_t4 = 20'h0;
        logic        iom_t1 = 1'b0;
        logic        dtr_t1 = 1'b0;
        bus.REQ       = 1'b1;
        bus.REQ_WR    = wr;
        bus.REQ_IO    = io;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wd;
        for (int c = 1; c <= 20 && ack_at == 0; c++) begin
            bus.READY = (c >= 4 && c < 4 + waits) ? 1'b0 : 1'b1;
            bus.AD_IN = adin;
            step();
            if (!bus.RD_N) rdlow++;
            if (!bus.WR_N) wrlow++;
            if (bus.AD_OE) begin
                oecnt++;
                adout_seen = bus.AD_OUT;
            end
            if (bus.ALE) begin
                a_t1   = bus.A;
                iom_t1 = bus.IOM;
                dtr_t1 = bus.DTR;
            end
            if (bus.ACK) begin
                ack_at = c;
                a_t4   = bus.A;
            end
        end
        bus.REQ   = 1'b0;
        bus.READY = 1'b1;
        chk({nm, " ack latency"}, ack_at, 4 + waits);
        chk({nm, " A at T1"}, a_t1, addr);
        chk({nm, " A at T4"}, a_t4, addr);
        chk({nm, " IOM at T1"}, iom_t1, io);
        chk({nm, " DTR at T1"}, dtr_t1, wr);
        chk({nm, " RD_N low cycles"}, rdlow, wr ? 0 : 2 + waits);
        chk({nm, " WR_N low cycles"}, wrlow, wr ? 2 + waits : 0);
        chk({nm, " AD_OE cycles"}, oecnt, wr ? 3 + waits : 0);
        if (wr) chk({nm, " AD_OUT"}, adout_seen, wd);
        else    chk({nm, " RDATA"}, bus.RDATA, adin);
        step();
        chk({nm, " ACK after"}, bus.ACK, 0);
        if (!wr) chk({nm, " RDATA held"}, bus.RDATA, adin);
    endtask

    initial begin
        bit found;
        int pushes;

        bus.REQ         = 1'b0;
        bus.REQ_WR      = 1'b0;
        bus.REQ_IO      = 1'b0;
        bus.REQ_ADDR    = '0;
        bus.REQ_WDATA   = '0;
        bus.READY       = 1'b1;
        bus.HOLD        = 1'b0;
        bus.AD_IN       = '0;
        bus.QUEUE_POP   = 1'b0;
        bus.QUEUE_FLUSH = 1'b0;
        bus.NEW_PC      = '0;

        // Four prefetches from FFFF0, each T1 T2 T3 T4 IDLE, then idle with a full queue
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 5; p++) begin
                tbl[k*5+p].ad_in = 8'hA0 + 8'(k);
                tbl[k*5+p].a     = 20'hFFFF0 + 20'(k);
                tbl[k*5+p].qin   = 8'hA0 + 8'(k);
                tbl[k*5+p].ale   = (p == 0);
                tbl[k*5+p].rd_n  = !(p == 1 || p == 2);
                tbl[k*5+p].den_n = !(p == 1 || p == 2);
                tbl[k*5+p].qena  = (p == 3);
                tbl[k*5+p].qc    = (p == 4) ? 3'(k + 1) : 3'(k);
            end
        end
        for (int r = 20; r < 24; r++) begin
            tbl[r].ad_in = 8'h00;
            tbl[r].a     = 20'hFFFF3;
            tbl[r].qin   = 8'hA3;
            tbl[r].ale   = 1'b0;
            tbl[r].rd_n  = 1'b1;
            tbl[r].den_n = 1'b1;
            tbl[r].qena  = 1'b0;
            tbl[r].qc    = 3'd4;
        end

        // Reset state
        repeat (2) @(posedge CLK);
        #2;
        chk("rst ALE", bus.ALE, 0);
        chk("rst RD_N", bus.RD_N, 1);
        chk("rst WR_N", bus.WR_N, 1);
        chk("rst DEN_N", bus.DEN_N, 1);
        chk("rst DTR", bus.DTR, 0);
        chk("rst IOM", bus.IOM, 0);
        chk("rst A", bus.A, 0);
        chk("rst AD_OUT", bus.AD_OUT, 0);
        chk("rst AD_OE", bus.AD_OE, 0);
        chk("rst HLDA", bus.HLDA, 0);
        chk("rst ACK", bus.ACK, 0);
        chk("rst RDATA", bus.RDATA, 0);
        chk("rst QUEUE_ENA", bus.QUEUE_ENA, 0);
        chk("rst QUEUE_IN", bus.QUEUE_IN, 0);
        chk("rst QCOUNT", bus.QCOUNT, 0);
        RST_N = 1'b1;

        // Prefetch table
        for (int r = 0; r < 24; r++) begin
            bus.AD_IN = tbl[r].ad_in;
            step();
            chk($sformatf("pf[%0d] ALE", r), bus.ALE, tbl[r].ale);
            chk($sformatf("pf[%0d] RD_N", r), bus.RD_N, tbl[r].rd_n);
            chk($sformatf("pf[%0d] DEN_N", r), bus.DEN_N, tbl[r].den_n);
            chk($sformatf("pf[%0d] IOM", r), bus.IOM, 0);
            chk($sformatf("pf[%0d] A", r), bus.A, tbl[r].a);
            chk($sformatf("pf[%0d] QUEUE_ENA", r), bus.QUEUE_ENA, tbl[r].qena);
            chk($sformatf("pf[%0d] QCOUNT", r), bus.QCOUNT, tbl[r].qc);
            if (tbl[r].qena) chk($sformatf("pf[%0d] QUEUE_IN", r), bus.QUEUE_IN, tbl[r].qin);
        end

        // Execution cycles
        exec_cycle("io read", 1'b0, 1'b1, 20'h00060, 8'h00, 8'h5A, 0);
        exec_cycle("mem write", 1'b1, 1'b0, 20'h12345, 8'hC3, 8'h00, 2);

        // Flush during a prefetch T3
        bus.QUEUE_POP = 1'b1;
        step();
        bus.QUEUE_POP = 1'b0;
        chk("pop QCOUNT", bus.QCOUNT, 3);
        for (int c = 0; c < 10 && !bus.ALE; c++) step();
        chk("refetch ALE", bus.ALE, 1);
        chk("refetch A", bus.A, 20'hFFFF4);
        step();
        step();
        chk("flush T3 RD_N", bus.RD_N, 0);
        bus.QUEUE_FLUSH = 1'b1;
        bus.NEW_PC      = 20'h01000;
        bus.AD_IN       = 8'h77;
        step();
        bus.QUEUE_FLUSH = 1'b0;
        chk("flush T4 QUEUE_ENA", bus.QUEUE_ENA, 0);
        chk("flush QCOUNT", bus.QCOUNT, 0);
        step();
        chk("flush idle QUEUE_ENA", bus.QUEUE_ENA, 0);
        chk("flush idle QCOUNT", bus.QCOUNT, 0);
        step();
        chk("post-flush ALE", bus.ALE, 1);
        chk("post-flush A", bus.A, 20'h01000);

        // Pop together with a push at QCOUNT=3
        found  = 1'b0;
        pushes = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            bus.AD_IN = 8'(c);
            step();
            if (bus.QUEUE_ENA) pushes++;
            if (bus.QUEUE_ENA && bus.QCOUNT == 3'd3) found = 1'b1;
        end
        chk("push at qc3 reached", found, 1);
        chk("pushes after flush", pushes, 4);
        chk("push at qc3 A", bus.A, 20'h01003);
        bus.QUEUE_POP = 1'b1;
        step();
        bus.QUEUE_POP = 1'b0;
        chk("pop+push QCOUNT", bus.QCOUNT, 3);

        // Let the queue refill, then HOLD during an execution T2
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (bus.QCOUNT == 3'd4) found = 1'b1;
        end
        chk("refill reached", found, 1);
        bus.REQ      = 1'b1;
        bus.REQ_WR   = 1'b0;
        bus.REQ_IO   = 1'b0;
        bus.REQ_ADDR = 20'h00200;
        bus.AD_IN    = 8'h3C;
        step();
        chk("hold T1 ALE", bus.ALE, 1);
        step();
        chk("hold T2 RD_N", bus.RD_N, 0);
        bus.HOLD = 1'b1;
        step();
        chk("hold T3 HLDA", bus.HLDA, 0);
        chk("hold T3 RD_N", bus.RD_N, 0);
        step();
        chk("hold T4 ACK", bus.ACK, 1);
        chk("hold T4 RDATA", bus.RDATA, 8'h3C);
        chk("hold T4 HLDA", bus.HLDA, 0);
        bus.REQ = 1'b0;
        step();
        chk("hold idle HLDA", bus.HLDA, 0);
        step();
        chk("hold HLDA", bus.HLDA, 1);
        chk("hold RD_N", bus.RD_N, 1);
        chk("hold WR_N", bus.WR_N, 1);
        chk("hold DEN_N", bus.DEN_N, 1);
        chk("hold ALE", bus.ALE, 0);
        step();
        chk("hold kept HLDA", bus.HLDA, 1);
        bus.HOLD = 1'b0;
        step();
        chk("hold release HLDA", bus.HLDA, 0);

        // Reset in the middle of a write cycle aborts it
        bus.REQ       = 1'b1;
        bus.REQ_WR    = 1'b1;
        bus.REQ_ADDR  = 20'h00555;
        bus.REQ_WDATA = 8'h99;
        step();
        step();
        step();
        chk("abort T3 WR_N", bus.WR_N, 0);
        #1;
        RST_N = 1'b0;
        #1;
        chk("abort WR_N", bus.WR_N, 1);
        chk("abort AD_OE", bus.AD_OE, 0);
        chk("abort A", bus.A, 0);
        chk("abort QCOUNT", bus.QCOUNT, 0);
        step();
        chk("abort ACK", bus.ACK, 0);
        chk("abort QUEUE_ENA", bus.QUEUE_ENA, 0);
        bus.REQ = 1'b0;
        RST_N   = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, meaning prefetch queue capacity in bytes.
REQ-002 SHALL have parameter RESET_VECTOR, default 20'hFFFF0, meaning physical address of the first prefetch after reset.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  async reset, active low.
- REQ  in  1  execution-unit bus request; held until ACK.
- REQ_WR  in  1  1 = write, 0 = read.
- REQ_IO  in  1  1 = I/O space, 0 = memory.
- REQ_ADDR  in  20  physical address.
- REQ_WDATA  in  8  write data.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  8  read data, valid with ACK and held until the next ACK.
- READY  in  1  bus ready; 0 inserts wait states.
- HOLD  in  1  external bus request.
- HLDA  out  1  hold acknowledge.
- ALE  out  1  address latch enable.
- RD_N, WR_N, DEN_N  out  1 each  active-low strobes.
- DTR  out  1  1 = transmit (write).
- IOM  out  1  1 = I/O cycle.
- A  out  20  bus address.
- AD_OUT  out  8  data driven onto AD.
- AD_OE  out  1  AD output enable.
- AD_IN  in  8  data sampled from AD.
- QUEUE_ENA  out  1  one-cycle push to the prefetch queue.
- QUEUE_IN  out  8  fetched code byte.
- QUEUE_POP  in  1  consumer removed one byte.
- QUEUE_FLUSH  in  1  discard queue contents; restart prefetch at NEW_PC.
- NEW_PC  in  20  physical restart address.
- QCOUNT  out  3  bytes held in the queue.

Function
REQ-005 FSM states SHALL be IDLE, T1, T2, T3, TW, T4 and HOLD_ST.
REQ-006 In IDLE, the next cycle SHALL be chosen by priority HOLD > REQ > prefetch; prefetch is eligible only when QCOUNT < QUEUE_DEPTH.
REQ-007 HOLD from IDLE SHALL go to HOLD_ST with HLDA=1 and all strobes inactive. The FSM SHALL return to IDLE one cycle after HOLD falls, at which point HLDA=0.
REQ-008 HOLD raised mid-cycle SHALL take effect only after T4.
REQ-009 In T1, A SHALL hold the address, ALE=1 and IOM/DTR SHALL be valid. A, IOM and DTR SHALL stay stable through T4.
REQ-010 In T2, T3 and TW, RD_N=0 (read) or WR_N=0 (write) and DEN_N=0. For a write, AD_OUT=REQ_WDATA and AD_OE=1 from T2 through T4.
REQ-011 In T3 and TW, READY=0 SHALL go to TW; READY=1 SHALL capture AD_IN (on reads) and go to T4.
REQ-012 In T4, strobes SHALL be inactive.
- Execution cycle: ACK=1 and RDATA updated.
- Prefetch cycle: QUEUE_ENA=1, QUEUE_IN = captured byte, prefetch address +1, wrapping at 20'hFFFFF to 0.
- Next state is IDLE.
REQ-013 With no wait states, ACK SHALL assert exactly 4 cycles after the FSM leaves IDLE (T1..T4).
REQ-014 Prefetch cycles SHALL always be memory reads (IOM=0, DTR=0).
REQ-015 QCOUNT SHALL update as follows:
- Push alone: +1.
- Pop alone: -1.
- Push and pop in the same cycle: unchanged.
- Pop at 0: ignored.
QCOUNT SHALL never exceed QUEUE_DEPTH.
REQ-016 QUEUE_FLUSH SHALL clear QUEUE_FLUSH-cycle state as follows, and SHALL override pop and push in the same cycle:
- QCOUNT = 0.
- Prefetch address loaded with NEW_PC.
REQ-017 A prefetch cycle in flight during a flush SHALL complete on the bus, but its byte SHALL be discarded (no QUEUE_ENA) and the prefetch address SHALL NOT increment.
REQ-018 Deasserting REQ before ACK is illegal; behaviour in that case is undefined.

Reset
REQ-019 RST_N=0 SHALL asynchronously set the following:
- State IDLE.
- ALE=0, RD_N=WR_N=DEN_N=1, DTR=0, IOM=0.
- A=0, AD_OUT=0, AD_OE=0.
- HLDA=0, ACK=0, RDATA=0.
- QUEUE_ENA=0, QUEUE_IN=0, QCOUNT=0.
- Prefetch address = RESET_VECTOR.
REQ-020 Reset asserted mid-cycle SHALL abort the cycle with no ACK or QUEUE_ENA.

Structure
REQ-021 A shared package SHALL hold the FSM state enum, QUEUE_DEPTH and RESET_VECTOR defaults.
REQ-022 The prefetch address counter and QCOUNT logic SHALL form one sub-module, biu_prefetch_ctrl.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release, READY=1, no REQ -> first T1 has A=20'hFFFF0; QUEUE_ENA pulses 4 times, one per fetch at FFFF0..FFFF3; then QCOUNT=4 and the bus stays idle.
- REQ read, IO=1, ADDR=20'h00060, AD_IN=8'h5A, READY=1 -> IOM=1, RD_N low in T2-T3, ACK 4 cycles later, RDATA=8'h5A.
- REQ write, WDATA=8'hC3, READY=0 for 2 cycles in T3 -> 2 TW states, WR_N low 4 cycles, AD_OE=1, ACK in the following T4.
- QUEUE_FLUSH with NEW_PC=20'h01000 during a prefetch T3 -> that byte is not pushed, QCOUNT=0, next fetch address is 20'h01000.
- HOLD=1 during an execution T2 -> cycle finishes with ACK, then HLDA=1 and strobes inactive; HOLD=0 -> HLDA=0 one cycle later.
- QUEUE_POP and a push in the same cycle at QCOUNT=3 -> QCOUNT stays 3.
